macc_vec_pipe: RTL and testbench

Pipelined, multi-lane multiply-accumulate processing element for the systolic PE array. It is the successor to the single-lane combinational MACC: parametrised lane count, selectable activation signedness, an internal accumulator spanning multi-beat groups, a saturating output and a valid/ready handshake with backpressure. Each accepted beat contributes the dot product of NUM_LANES activation/weight pairs. A group result is emitted downstream on the group's last beat.

---
 rtl/pe_pkg.sv | 34 +++
 rtl/macc_lane_mult.sv | 17 +
 rtl/macc_vec_pipe.sv | 129 ++++++++++++
 tb/tb_macc_vec_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared sizing helpers and saturation bounds for the MACC processing elements.
package pe_pkg;

    localparam int unsigned SAT_CONST_W = 256;
    typedef logic signed [SAT_CONST_W-1:0] sat_const_t;

    function automatic int unsigned prod_width(input int unsigned act_w, input int unsigned wgt_w);
        return act_w + wgt_w + 1;
    endfunction

    function automatic int unsigned dot_width(input int unsigned act_w, input int unsigned wgt_w,
                                              input int unsigned lanes);
        return prod_width(act_w, wgt_w) + $clog2(lanes);
    endfunction

    function automatic int unsigned max_width(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

    // Bounds are built wide and truncated by the caller to its own arithmetic width.
    function automatic sat_const_t sat_max(input int unsigned out_w);
        sat_const_t r;
        r = '0;
        r[out_w-1] = 1'b1;
        return r - sat_const_t'(1);
    endfunction

    function automatic sat_const_t sat_min(input int unsigned out_w);
        sat_const_t r;
        r = '1;
        return r << (out_w - 1);
    endfunction

endpackage

// File: rtl/macc_lane_mult.sv
// One lane: activation extension selected by act_signed, then signed multiply by the weight.
module macc_lane_mult #(
    parameter int unsigned ACT_BITWIDTH = 16,
    parameter int unsigned WGT_BITWIDTH = 16
) (
    input  logic [ACT_BITWIDTH-1:0]                       a,
    input  logic [WGT_BITWIDTH-1:0]                       w,
    input  logic                                          act_signed,
    output logic signed [ACT_BITWIDTH+WGT_BITWIDTH:0]     prod
);

    logic signed [ACT_BITWIDTH:0] a_ext;

    assign a_ext = {act_signed & a[ACT_BITWIDTH-1], a};
    assign prod  = a_ext * $signed(w);

endmodule

// File: rtl/macc_vec_pipe.sv
// Two-stage multi-lane MACC: S1 registers lane products, S2 sums, accumulates, saturates and emits.
module macc_vec_pipe
    import pe_pkg::*;
#(
    parameter int unsigned NUM_LANES       = 4,
    parameter int unsigned ACT_BITWIDTH    = 16,
    parameter int unsigned WGT_BITWIDTH    = 16,
    parameter int unsigned SUM_IN_BITWIDTH = 64,
    parameter int unsigned OUT_BITWIDTH    = 64
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM_LANES*ACT_BITWIDTH-1:0]      a_in,
    input  logic [NUM_LANES*WGT_BITWIDTH-1:0]      w_in,
    input  logic signed [SUM_IN_BITWIDTH-1:0]      sum_in,
    input  logic                                   act_signed,
    input  logic                                   in_first,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic signed [OUT_BITWIDTH-1:0]         out,
    output logic                                   out_sat
);

    localparam int unsigned PROD_W = prod_width(ACT_BITWIDTH, WGT_BITWIDTH);
    localparam int unsigned DOT_W  = dot_width(ACT_BITWIDTH, WGT_BITWIDTH, NUM_LANES);
    localparam int unsigned SUM_W  = max_width(OUT_BITWIDTH, DOT_W) + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(sat_max(OUT_BITWIDTH));
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(sat_min(OUT_BITWIDTH));

    logic stall;

    logic signed [PROD_W-1:0]           prod    [NUM_LANES];
    logic signed [PROD_W-1:0]           s1_prod [NUM_LANES];
    logic                               s1_valid;
    logic                               s1_first;
    logic                               s1_last;
    logic signed [SUM_IN_BITWIDTH-1:0]  s1_sum_in;

    logic signed [OUT_BITWIDTH-1:0]     acc;
    logic                               sat_flag;

    logic signed [DOT_W-1:0]            dot;
    logic signed [OUT_BITWIDTH-1:0]     seed;
    logic signed [SUM_W-1:0]            sum_full;
    logic                               clamp;
    logic signed [OUT_BITWIDTH-1:0]     next_acc;
    logic                               next_flag;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        macc_lane_mult #(
            .ACT_BITWIDTH(ACT_BITWIDTH),
            .WGT_BITWIDTH(WGT_BITWIDTH)
        ) u_mult (
            .a         (a_in[g*ACT_BITWIDTH +: ACT_BITWIDTH]),
            .w         (w_in[g*WGT_BITWIDTH +: WGT_BITWIDTH]),
            .act_signed(act_signed),
            .prod      (prod[g])
        );
    end

    // S1: a held beat stays registered while the output is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_sum_in <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                s1_prod[i] <= '0;
            end
        end else if (!stall) begin
            s1_valid  <= in_valid;
            s1_first  <= in_first;
            s1_last   <= in_last;
            s1_sum_in <= sum_in;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                s1_prod[i] <= prod[i];
            end
        end
    end

    always_comb begin
        dot = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            dot = dot + DOT_W'(s1_prod[i]);
        end
        seed      = s1_first ? OUT_BITWIDTH'(s1_sum_in) : acc;
        sum_full  = SUM_W'(seed) + SUM_W'(dot);
        clamp     = 1'b0;
        next_acc  = OUT_BITWIDTH'(sum_full);
        if (sum_full > SAT_MAX) begin
            clamp    = 1'b1;
            next_acc = OUT_BITWIDTH'(SAT_MAX);
        end else if (sum_full < SAT_MIN) begin
            clamp    = 1'b1;
            next_acc = OUT_BITWIDTH'(SAT_MIN);
        end
        next_flag = (s1_first ? 1'b0 : sat_flag) | clamp;
    end

    // S2: when not stalled, out_valid either clears (handshake or idle) or reloads on a last beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            sat_flag  <= 1'b0;
            out       <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= s1_valid && s1_last;
            if (s1_valid) begin
                acc      <= next_acc;
                sat_flag <= next_flag;
                if (s1_last) begin
                    out     <= next_acc;
                    out_sat <= next_flag;
                end
            end
        end
    end

endmodule

// File: tb/tb_macc_vec_pipe.sv
// Self-checking bench for macc_vec_pipe: directed vector table, corner sequences, random vs model.
module tb_macc_vec_pipe;

    localparam int L  = 4;
    localparam int AW = 16;
    localparam int WW = 16;
    localparam int SW = 64;
    localparam int OW = 64;

    localparam logic signed [127:0] MAXV = 128'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [127:0] MINV = -MAXV - 128'sd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [L*AW-1:0]       a_in;
    logic [L*WW-1:0]       w_in;
    logic signed [SW-1:0]  sum_in;
    logic                  act_signed;
    logic                  in_first;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [OW-1:0]  out;
    logic                  out_sat;

    macc_vec_pipe #(
        .NUM_LANES      (L),
        .ACT_BITWIDTH   (AW),
        .WGT_BITWIDTH   (WW),
        .SUM_IN_BITWIDTH(SW),
        .OUT_BITWIDTH   (OW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .w_in      (w_in),
        .sum_in    (sum_in),
        .act_signed(act_signed),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_sat   (out_sat)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic signed [OW-1:0] v;
        logic                 s;
    } res_t;

    res_t exp_q[$];
    logic signed [127:0] m_acc;
    logic                m_flag;

    logic                 obs_in_fire;
    logic                 obs_out_fire;
    logic                 obs_out_valid;
    logic                 obs_in_ready;
    logic signed [OW-1:0] obs_out;

    typedef struct {
        string                name;
        logic [L*AW-1:0]      a;
        logic [L*WW-1:0]      w;
        logic                 act_s;
        logic signed [SW-1:0] sum;
        logic signed [OW-1:0] exp_out;
        logic                 exp_sat;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: group accumulation computed with plain wide integer arithmetic.
    task automatic model_beat();
        longint d;
        longint ae;
        longint we;
        logic [AW-1:0] al;
        logic [WW-1:0] wl;
        logic signed [127:0] seed;
        logic signed [127:0] t;
        logic c;
        res_t r;
        d = 0;
        for (int i = 0; i < L; i++) begin
            al = a_in[i*AW +: AW];
            wl = w_in[i*WW +: WW];
            ae = act_signed ? longint'($signed(al)) : longint'(al);
            we = longint'($signed(wl));
            d  = d + ae * we;
        end
        seed = in_first ? 128'(sum_in) : m_acc;
        t    = seed + 128'(d);
        c    = 1'b0;
        if (t > MAXV) begin t = MAXV; c = 1'b1; end
        if (t < MINV) begin t = MINV; c = 1'b1; end
        m_flag = (in_first ? 1'b0 : m_flag) | c;
        m_acc  = t;
        if (in_last) begin
            r.v = t[OW-1:0];
            r.s = m_flag;
            exp_q.push_back(r);
        end
    endtask

    task automatic model_reset();
        m_acc  = '0;
        m_flag = 1'b0;
        exp_q.delete();
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        res_t e;
        #1;
        obs_out_valid = out_valid;
        obs_out       = out;
        obs_in_ready  = in_ready;
        obs_in_fire   = in_valid && in_ready;
        obs_out_fire  = out_valid && out_ready;
        if (reset_n) check("in_ready_rule", in_ready, !(out_valid && !out_ready));
        if (obs_out_fire) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%0h required=none", out);
            end else begin
                e = exp_q.pop_front();
                check("model_out", out, e.v);
                check("model_sat", out_sat, e.s);
            end
        end
        if (obs_in_fire) model_beat();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_expect(input string name, input logic [L*AW-1:0] a, input logic [L*WW-1:0] w,
                               input logic s, input logic signed [SW-1:0] sum, input logic first,
                               input logic signed [OW-1:0] eo, input logic es);
        int n;
        a_in = a; w_in = w; act_signed = s; sum_in = sum;
        in_first = first; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check({name, "_accept"}, obs_in_fire, 1'b1);
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        n = 0;
        while (n < 10 && !out_valid) begin
            tick();
            n++;
        end
        check({name, "_latency"}, n, 1);
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_out"}, out, eo);
        check({name, "_sat"}, out_sat, es);
        tick();
        check({name, "_valid_clr"}, out_valid, 1'b0);
    endtask

    initial begin
        int n;
        int idx;
        int stable_err;
        bit saw_low;
        bit have_held;
        logic signed [OW-1:0] held;
        logic signed [OW-1:0] got[$];
        logic signed [OW-1:0] v;

        tbl[0] = '{"unsigned_single", {16'd3, 16'd2, 16'd1, 16'hFFFF}, {16'd6, 16'd5, 16'd4, 16'hFFFF},
                   1'b0, 64'sd10, -64'sd65493, 1'b0};
        tbl[1] = '{"signed_neg1", {4{16'hFFFF}}, {4{16'hFFFF}}, 1'b1, 64'sd0, 64'sd4, 1'b0};
        tbl[2] = '{"sat_pos", {48'd0, 16'd5}, {48'd0, 16'd1}, 1'b1, 64'sh7FFF_FFFF_FFFF_FFFE,
                   64'sh7FFF_FFFF_FFFF_FFFF, 1'b1};
        tbl[3] = '{"after_sat", {48'd0, 16'd1}, {48'd0, 16'd1}, 1'b1, 64'sd0, 64'sd1, 1'b0};
        tbl[4] = '{"sat_neg", {48'd0, 16'h8000}, {48'd0, 16'h7FFF}, 1'b1, 64'sh8000_0000_0000_0001,
                   64'sh8000_0000_0000_0000, 1'b1};
        tbl[5] = '{"unsigned_max", {4{16'hFFFF}}, {4{16'h7FFF}}, 1'b0, -64'sd1, 64'sd8589541379, 1'b0};

        reset_n = 1'b0; in_valid = 1'b0; a_in = '0; w_in = '0; sum_in = '0;
        act_signed = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, 64'd0);
        check("rst_out_sat", out_sat, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send_expect(tbl[i].name, tbl[i].a, tbl[i].w, tbl[i].act_s, tbl[i].sum, 1'b1,
                        tbl[i].exp_out, tbl[i].exp_sat);
        end

        // Three-beat group, back to back: 100 + 20 - 5 + 7.
        act_signed = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        a_in = {48'd0, 16'd20}; w_in = {48'd0, 16'd1}; sum_in = 64'sd100; in_first = 1'b1; in_last = 1'b0;
        tick();
        a_in = {48'd0, 16'd5}; w_in = {48'd0, 16'hFFFF}; sum_in = 64'sd999; in_first = 1'b0;
        tick();
        check("multi_no_early_out1", out_valid, 1'b0);
        a_in = {48'd0, 16'd7}; w_in = {48'd0, 16'd1}; in_last = 1'b1;
        tick();
        check("multi_no_early_out2", out_valid, 1'b0);
        in_valid = 1'b0; in_last = 1'b0;
        n = 0; v = '0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) begin n++; v = out; end
            tick();
        end
        check("multi_count", n, 1);
        check("multi_out", v, 64'sd122);

        // Backpressure: three results, downstream not ready for the first five cycles.
        idx = 0; stable_err = 0; saw_low = 1'b0; have_held = 1'b0; held = '0;
        act_signed = 1'b0; a_in = '0; w_in = '0; in_first = 1'b1; in_last = 1'b1;
        for (int c = 0; c < 30; c++) begin
            out_ready = (c >= 5);
            in_valid  = (idx < 3);
            sum_in    = 64'(11 * (idx + 1));
            tick();
            if (obs_in_fire) idx++;
            if (!obs_in_ready) saw_low = 1'b1;
            if (obs_out_valid && !out_ready) begin
                if (have_held && obs_out !== held) stable_err++;
                held = obs_out;
                have_held = 1'b1;
            end
            if (obs_out_fire) got.push_back(obs_out);
        end
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        check("bp_all_accepted", idx, 3);
        check("bp_in_ready_dropped", saw_low, 1'b1);
        check("bp_out_stable", stable_err, 0);
        check("bp_count", got.size(), 3);
        for (int i = 0; i < 3; i++) begin
            v = (i < got.size()) ? got[i] : 64'sd0;
            check($sformatf("bp_res%0d", i), v, 64'(11 * (i + 1)));
        end

        // Reset in the middle of a group.
        act_signed = 1'b1; in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0;
        a_in = {48'd0, 16'd9}; w_in = {48'd0, 16'd9}; sum_in = 64'sd500;
        tick();
        in_first = 1'b0;
        tick();
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_out", out, 64'd0);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_sat", out_sat, 1'b0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_expect("after_rst", {48'd0, 16'd3}, {48'd0, 16'd1}, 1'b1, 64'sd7, 1'b1, 64'sd10, 1'b0);

        // A group lacking in_first straight after reset accumulates onto 0.
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_expect("no_first", {48'd0, 16'd5}, {48'd0, 16'd1}, 1'b1, 64'sd1234, 1'b0, 64'sd5, 1'b0);

        // Random traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            in_first   = ($urandom_range(0, 3) == 0);
            in_last    = ($urandom_range(0, 2) == 0);
            act_signed = $urandom_range(0, 1);
            a_in       = {$urandom, $urandom};
            w_in       = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: sum_in = 64'sh7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 1 << 20));
                1: sum_in = 64'sh8000_0000_0000_0000 + 64'($urandom_range(0, 1 << 20));
                default: sum_in = {$urandom, $urandom};
            endcase
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        check("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
